// File: rtl/id_ex_if.sv
// Bus bundle between the decode side, the forwarding sources and the ID/EX stage.
// The stage connects through the slave modport; clk and rst_n stay plain ports.
interface id_ex_if;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_uses_rt;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_shamt;
  logic [3:0]  id_alu_op;
  logic        id_alu_src;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_mem_write;
  logic        id_mem_to_reg;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [4:0]  shamt;
  logic [3:0]  ALUsignal;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic [4:0]  ex_rd;
  logic [31:0] ex_store_data;
  logic        load_use_stall;

  modport master (
    output stall, flush, id_valid, id_rs, id_rt, id_rd, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_op, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    input  op1, op2, shamt, ALUsignal, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, ex_rd, ex_store_data, load_use_stall
  );

  modport slave (
    input  stall, flush, id_valid, id_rs, id_rt, id_rd, id_uses_rt,
           id_rs_data, id_rt_data, id_imm, id_shamt, id_alu_op, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_data,
    output op1, op2, shamt, ALUsignal, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_mem_to_reg, ex_rd, ex_store_data, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW forwarding and load-use stall detection.
// Define ID_EX_FORWARDING_EN for EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall.
module id_ex_stage (
  input logic   clk,
  input logic   rst_n,
  id_ex_if.slave bus
);
  logic        valid_reg;
  logic [4:0]  rs_reg;
  logic [4:0]  rt_reg;
  logic [4:0]  rd_reg;
  logic [31:0] rs_data_reg;
  logic [31:0] rt_data_reg;
  logic [31:0] imm_reg;
  logic [4:0]  shamt_reg;
  logic [3:0]  alu_op_reg;
  logic        alu_src_reg;
  logic        reg_write_reg;
  logic        mem_read_reg;
  logic        mem_write_reg;
  logic        mem_to_reg_reg;

  logic        hit_ex;
  logic        load_use;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  assign hit_ex = (bus.id_rs == rd_reg) || (bus.id_uses_rt && bus.id_rt == rd_reg);

`ifdef ID_EX_FORWARDING_EN
  assign load_use = valid_reg && mem_read_reg && rd_reg != 5'd0 && bus.id_valid && hit_ex;

  always_comb begin
    rs_fwd = rs_data_reg;
    rt_fwd = rt_data_reg;
    if (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == rs_reg)
      rs_fwd = bus.exmem_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != 5'd0 && bus.memwb_rd == rs_reg)
      rs_fwd = bus.memwb_data;
    if (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && bus.exmem_rd == rt_reg)
      rt_fwd = bus.exmem_result;
    else if (bus.memwb_reg_write && bus.memwb_rd != 5'd0 && bus.memwb_rd == rt_reg)
      rt_fwd = bus.memwb_data;
  end
`else
  logic hit_exmem;
  logic unused_fwd;

  // Without muxes any producer still in EX or EX/MEM must stall the reader;
  // MEM/WB is covered by the register file writing before it reads.
  assign hit_exmem = (bus.id_rs == bus.exmem_rd) ||
                     (bus.id_uses_rt && bus.id_rt == bus.exmem_rd);
  assign load_use  = bus.id_valid &&
                     ((valid_reg && reg_write_reg && rd_reg != 5'd0 && hit_ex) ||
                      (bus.exmem_reg_write && bus.exmem_rd != 5'd0 && hit_exmem));
  assign rs_fwd     = rs_data_reg;
  assign rt_fwd     = rt_data_reg;
  assign unused_fwd = ^{bus.memwb_reg_write, bus.memwb_rd, bus.memwb_data,
                        bus.exmem_result, rs_reg, rt_reg};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      rs_reg         <= '0;
      rt_reg         <= '0;
      rd_reg         <= '0;
      rs_data_reg    <= '0;
      rt_data_reg    <= '0;
      imm_reg        <= '0;
      shamt_reg      <= '0;
      alu_op_reg     <= '0;
      alu_src_reg    <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
    end else if (bus.flush || (!bus.stall && load_use)) begin
      // Flush beats stall; a load-use bubble only enters when not held.
      valid_reg      <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
    end else if (!bus.stall) begin
      valid_reg      <= bus.id_valid;
      rs_reg         <= bus.id_rs;
      rt_reg         <= bus.id_rt;
      rd_reg         <= bus.id_rd;
      rs_data_reg    <= bus.id_rs_data;
      rt_data_reg    <= bus.id_rt_data;
      imm_reg        <= bus.id_imm;
      shamt_reg      <= bus.id_shamt;
      alu_op_reg     <= bus.id_alu_op;
      alu_src_reg    <= bus.id_alu_src;
      reg_write_reg  <= bus.id_reg_write;
      mem_read_reg   <= bus.id_mem_read;
      mem_write_reg  <= bus.id_mem_write;
      mem_to_reg_reg <= bus.id_mem_to_reg;
    end
  end

  assign bus.op1            = rs_fwd;
  assign bus.op2            = alu_src_reg ? imm_reg : rt_fwd;
  assign bus.ex_store_data  = rt_fwd;
  assign bus.shamt          = shamt_reg;
  assign bus.ALUsignal      = alu_op_reg;
  assign bus.ex_valid       = valid_reg;
  assign bus.ex_reg_write   = valid_reg & reg_write_reg;
  assign bus.ex_mem_read    = valid_reg & mem_read_reg;
  assign bus.ex_mem_write   = valid_reg & mem_write_reg;
  assign bus.ex_mem_to_reg  = valid_reg & mem_to_reg_reg;
  assign bus.ex_rd          = rd_reg;
  assign bus.load_use_stall = load_use;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed sequences, a forwarding vector table and
// randomized traffic checked against a slot-level reference model.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_if bus ();
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        uses_rt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } id_t;

  typedef struct {
    logic [4:0]  rs, rt;
    logic [31:0] rsd, rtd, imm;
    logic        src, xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic [31:0] f1, f2, fs, n1, n2, ns;
  } vec_t;

  id_t         cur, m;
  logic        stall_v, flush_v, xw, ww;
  logic [4:0]  xrd, wrd;
  logic [31:0] xres, wdata;
  int          checks = 0;
  int          errors = 0;
  vec_t        tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive();
    bus.stall = stall_v;             bus.flush = flush_v;
    bus.id_valid = cur.valid;        bus.id_rs = cur.rs;
    bus.id_rt = cur.rt;              bus.id_rd = cur.rd;
    bus.id_uses_rt = cur.uses_rt;    bus.id_rs_data = cur.rs_data;
    bus.id_rt_data = cur.rt_data;    bus.id_imm = cur.imm;
    bus.id_shamt = cur.shamt;        bus.id_alu_op = cur.alu_op;
    bus.id_alu_src = cur.alu_src;    bus.id_reg_write = cur.reg_write;
    bus.id_mem_read = cur.mem_read;  bus.id_mem_write = cur.mem_write;
    bus.id_mem_to_reg = cur.mem_to_reg;
    bus.exmem_reg_write = xw;  bus.exmem_rd = xrd;  bus.exmem_result = xres;
    bus.memwb_reg_write = ww;  bus.memwb_rd = wrd;  bus.memwb_data = wdata;
  endtask

  function automatic logic [31:0] fwd_val(input logic [4:0] r, input logic [31:0] d);
`ifdef ID_EX_FORWARDING_EN
    if (xw && xrd != 0 && xrd == r) return xres;
    if (ww && wrd != 0 && wrd == r) return wdata;
`endif
    return d;
  endfunction

  function automatic logic reads(input logic [4:0] r);
    return r != 0 && (cur.rs == r || (cur.uses_rt && cur.rt == r));
  endfunction

  function automatic logic exp_lus();
`ifdef ID_EX_FORWARDING_EN
    return cur.valid && m.valid && m.mem_read && reads(m.rd);
`else
    return cur.valid && ((m.valid && m.reg_write && reads(m.rd)) || (xw && reads(xrd)));
`endif
  endfunction

  task automatic clear_ctl();
    m.valid = 0; m.reg_write = 0; m.mem_read = 0; m.mem_write = 0; m.mem_to_reg = 0;
  endtask

  task automatic tick();
    if (!rst_n) m = '0;
    else if (flush_v) clear_ctl();
    else if (!stall_v) begin
      if (exp_lus()) clear_ctl();
      else m = cur;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all();
    logic [31:0] rtf;
    chk("load_use_stall", bus.load_use_stall, exp_lus());
    chk("ex_valid", bus.ex_valid, m.valid);
    chk("ex_reg_write", bus.ex_reg_write, m.valid & m.reg_write);
    chk("ex_mem_read", bus.ex_mem_read, m.valid & m.mem_read);
    chk("ex_mem_write", bus.ex_mem_write, m.valid & m.mem_write);
    chk("ex_mem_to_reg", bus.ex_mem_to_reg, m.valid & m.mem_to_reg);
    if (m.valid) begin
      rtf = fwd_val(m.rt, m.rt_data);
      chk("op1", bus.op1, fwd_val(m.rs, m.rs_data));
      chk("op2", bus.op2, m.alu_src ? m.imm : rtf);
      chk("ex_store_data", bus.ex_store_data, rtf);
      chk("shamt", bus.shamt, m.shamt);
      chk("ALUsignal", bus.ALUsignal, m.alu_op);
      chk("ex_rd", bus.ex_rd, m.rd);
    end
  endtask

  initial begin
    tbl[0] = '{5'd3, 5'd1, 32'h11, 32'h22, 32'h99, 1'b0, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB,
               32'hAA, 32'h22, 32'h22, 32'h11, 32'h22, 32'h22};
    tbl[1] = '{5'd3, 5'd1, 32'h11, 32'h22, 32'h99, 1'b0, 1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB,
               32'hBB, 32'h22, 32'h22, 32'h11, 32'h22, 32'h22};
    tbl[2] = '{5'd0, 5'd0, 32'h11, 32'h22, 32'h99, 1'b0, 1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB,
               32'h11, 32'h22, 32'h22, 32'h11, 32'h22, 32'h22};
    tbl[3] = '{5'd1, 5'd6, 32'h40, 32'h66, 32'h08, 1'b1, 1'b1, 5'd6, 32'h1234, 1'b0, 5'd0, 32'h0,
               32'h40, 32'h08, 32'h1234, 32'h40, 32'h08, 32'h66};
    tbl[4] = '{5'd2, 5'd5, 32'h10, 32'h20, 32'h99, 1'b0, 1'b1, 5'd7, 32'hCC, 1'b1, 5'd5, 32'hDD,
               32'h10, 32'hDD, 32'hDD, 32'h10, 32'h20, 32'h20};
    tbl[5] = '{5'd9, 5'd9, 32'h01, 32'h02, 32'h99, 1'b0, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0, 32'h0,
               32'h77, 32'h77, 32'h77, 32'h01, 32'h02, 32'h02};

    // Reset held with busy decode inputs.
    m = '0; stall_v = 0; flush_v = 0;
    xw = 0; xrd = 0; xres = 0; ww = 0; wrd = 0; wdata = 0;
    cur = '{valid:1, rs:3, rt:4, rd:5, uses_rt:1, rs_data:32'h5A, rt_data:32'hA5, imm:32'h33,
            shamt:5'd7, alu_op:4'd8, alu_src:1, reg_write:1, mem_read:1, mem_write:1, mem_to_reg:1};
    drive();
    tick(); tick();
    @(negedge clk);
    chk("rst op1", bus.op1, 0);                 chk("rst op2", bus.op2, 0);
    chk("rst ALUsignal", bus.ALUsignal, 0);     chk("rst shamt", bus.shamt, 0);
    chk("rst ex_valid", bus.ex_valid, 0);       chk("rst ex_reg_write", bus.ex_reg_write, 0);
    chk("rst ex_mem_read", bus.ex_mem_read, 0); chk("rst ex_mem_write", bus.ex_mem_write, 0);
    chk("rst ex_rd", bus.ex_rd, 0);             chk("rst ex_store_data", bus.ex_store_data, 0);
    chk("rst load_use_stall", bus.load_use_stall, 0);
    $display("txn reset-hold: outputs checked at zero");
    @(posedge clk); #1;
    rst_n = 1;
    cur = '0; cur.valid = 1; cur.rs = 1; cur.rt = 2; cur.rd = 3;
    cur.rs_data = 5; cur.imm = 7; cur.alu_src = 1;
    drive(); tick();
    cur.valid = 0; drive();
    @(negedge clk);
    chk("first op1", bus.op1, 5); chk("first op2", bus.op2, 7); chk("first ex_valid", bus.ex_valid, 1);
    $display("txn first-capture: op1=%h op2=%h", bus.op1, bus.op2);
    tick();

    // Forwarding vector table.
    for (int i = 0; i < 6; i++) begin
      xw = 0; ww = 0;
      cur = '0; cur.valid = 1; cur.uses_rt = 1; cur.rd = 5'd10;
      cur.rs = tbl[i].rs; cur.rt = tbl[i].rt; cur.rs_data = tbl[i].rsd;
      cur.rt_data = tbl[i].rtd; cur.imm = tbl[i].imm; cur.alu_src = tbl[i].src;
      drive(); tick();
      cur.valid = 0;
      xw = tbl[i].xw; xrd = tbl[i].xrd; xres = tbl[i].xres;
      ww = tbl[i].ww; wrd = tbl[i].wrd; wdata = tbl[i].wdata;
      drive();
      @(negedge clk);
`ifdef ID_EX_FORWARDING_EN
      chk("vec op1", bus.op1, tbl[i].f1); chk("vec op2", bus.op2, tbl[i].f2);
      chk("vec store", bus.ex_store_data, tbl[i].fs);
`else
      chk("vec op1", bus.op1, tbl[i].n1); chk("vec op2", bus.op2, tbl[i].n2);
      chk("vec store", bus.ex_store_data, tbl[i].ns);
`endif
      $display("txn vec%0d: op1=%h op2=%h store=%h", i, bus.op1, bus.op2, bus.ex_store_data);
      tick();
    end
    xw = 0; ww = 0;

    // Load-use: lw r4 in EX, add reads r4.
    cur = '0; cur.valid = 1; cur.rs = 1; cur.rt = 2; cur.rd = 4;
    cur.reg_write = 1; cur.mem_read = 1; cur.mem_to_reg = 1; cur.alu_src = 1;
    drive(); tick();
    cur = '0; cur.valid = 1; cur.rs = 4; cur.rt = 5; cur.rd = 6; cur.uses_rt = 1;
    cur.reg_write = 1; cur.rs_data = 32'h30; cur.rt_data = 32'h31;
    drive();
    @(negedge clk);
    chk("lu stall", bus.load_use_stall, 1); chk("lu lw ex_mem_read", bus.ex_mem_read, 1);
    tick();
    @(negedge clk);
    chk("lu bubble stall", bus.load_use_stall, 0); chk("lu bubble ex_valid", bus.ex_valid, 0);
    chk("lu bubble ex_reg_write", bus.ex_reg_write, 0);
    tick();
    @(negedge clk);
    chk("lu add ex_valid", bus.ex_valid, 1); chk("lu add ex_rd", bus.ex_rd, 6);
    chk("lu add ex_reg_write", bus.ex_reg_write, 1);
    $display("txn load-use: bubble then add rd=%0d", bus.ex_rd);

    // Stall holds for three cycles, then flush+stall bubbles.
    stall_v = 1;
    cur = '0; cur.valid = 1; cur.rs = 7; cur.rd = 8; cur.rs_data = 32'h55;
    drive();
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk("stall op1", bus.op1, 32'h30); chk("stall ex_rd", bus.ex_rd, 6);
      chk("stall ex_valid", bus.ex_valid, 1);
    end
    flush_v = 1; drive(); tick();
    @(negedge clk);
    chk("flush ex_valid", bus.ex_valid, 0); chk("flush ex_reg_write", bus.ex_reg_write, 0);
    $display("txn stall-flush: ex_valid=%0d", bus.ex_valid);
    stall_v = 0; flush_v = 0;

    // RAW against a non-load in EX: stalls only without forwarding.
    cur = '0; cur.valid = 1; cur.rs = 1; cur.rt = 1; cur.rd = 2; cur.reg_write = 1;
    drive(); tick();
    cur = '0; cur.valid = 1; cur.rs = 2; cur.rt = 3; cur.uses_rt = 1; cur.rd = 9;
    cur.rs_data = 32'h42;
    drive();
    @(negedge clk);
`ifdef ID_EX_FORWARDING_EN
    chk("alu raw stall", bus.load_use_stall, 0);
`else
    chk("alu raw stall", bus.load_use_stall, 1);
`endif
    $display("txn alu-raw: load_use_stall=%0d", bus.load_use_stall);
    tick(); tick();
    cur.valid = 0; drive();

    // Asynchronous reset mid-cycle.
    @(negedge clk);
    chk("pre-rst ex_valid", bus.ex_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("async rst ex_valid", bus.ex_valid, 0); chk("async rst op1", bus.op1, 0);
    $display("txn async-reset: ex_valid=%0d", bus.ex_valid);
    m = '0;
    @(posedge clk); #1;
    rst_n = 1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      stall_v = ($urandom_range(0, 7) == 0);
      flush_v = ($urandom_range(0, 9) == 0);
      cur.valid = ($urandom_range(0, 3) != 0);
      cur.rs = 5'($urandom_range(0, 3));      cur.rt = 5'($urandom_range(0, 3));
      cur.rd = 5'($urandom_range(0, 3));      cur.uses_rt = ($urandom_range(0, 1) == 1);
      cur.rs_data = $urandom;  cur.rt_data = $urandom;  cur.imm = $urandom;
      cur.shamt = 5'($urandom_range(0, 31));  cur.alu_op = 4'($urandom_range(0, 8));
      cur.alu_src = ($urandom_range(0, 1) == 1);  cur.reg_write = ($urandom_range(0, 1) == 1);
      cur.mem_read = ($urandom_range(0, 2) == 0); cur.mem_write = ($urandom_range(0, 3) == 0);
      cur.mem_to_reg = ($urandom_range(0, 1) == 1);
      xw = ($urandom_range(0, 1) == 1);  xrd = 5'($urandom_range(0, 3));  xres = $urandom;
      ww = ($urandom_range(0, 1) == 1);  wrd = 5'($urandom_range(0, 3));  wdata = $urandom;
      drive();
      @(negedge clk);
      check_all();
      $display("txn rnd%0d: v=%0d op1=%h op2=%h lus=%0d", i, bus.ex_valid, bus.op1, bus.op2,
               bus.load_use_stall);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
